// File: rtl/ovc_credit_tx_pkg.sv
// Shared constants and types for the output-port transmit controller.
//   FLIT_SIZE / HEADER_LEN : flit width and width of the type field at the MSBs
//   *_FLIT                 : flit type encodings
//   VC_SIZE                : default downstream VC buffer depth (credits)
//   ovc_state_e            : per-OVC ownership state
package ovc_credit_tx_pkg;

  localparam int FLIT_SIZE  = 32;
  localparam int HEADER_LEN = 2;
  localparam int VC_SIZE    = 8;

  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'd0;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'd1;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'd2;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ovc_state_e;

  // A tail or single flit closes the packet and frees its OVC.
  function automatic logic is_last_flit(input logic [HEADER_LEN-1:0] ftype);
    return (ftype == TAIL_FLIT) || (ftype == SINGLE_FLIT);
  endfunction

endpackage

// File: rtl/ovc_credit_tx_credit_counter.sv
// Credit counter for one downstream OVC.
//   clk, rst    : clock, synchronous active-high reset (count -> VC_SIZE)
//   dec         : a flit is being sent on this OVC
//   inc         : a credit is being returned for this OVC
//   count       : current credit count, 0..VC_SIZE
//   nonzero     : count > 0
//   underflow   : pulse, send attempted with no credit (the send is ignored)
//   overflow    : pulse, credit returned while already full (saturates)
module ovc_credit_tx_credit_counter #(
  parameter int VC_SIZE = 8,
  parameter int CNT_W   = $clog2(VC_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             underflow,
  output logic             overflow
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_eff;
  logic             at_max;

  always_comb begin
    nonzero   = (count_q != '0);
    at_max    = (count_q == CNT_W'(VC_SIZE));
    // A send with no credit is dropped upstream, so it consumes nothing.
    dec_eff   = dec & nonzero;
    underflow = dec & ~nonzero;
    // A same-cycle accepted send makes room for the credit, so no overflow.
    overflow  = inc & ~dec_eff & at_max;
    count_d   = count_q;
    if (dec_eff && !inc)
      count_d = count_q - 1'b1;
    else if (inc && !dec_eff && !at_max)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= CNT_W'(VC_SIZE);
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ovc_credit_tx.sv
// Output-port transmit controller: allocates downstream OVCs to head/single
// flits, tracks per-OVC credits and forwards flits to the link.
//   clk, rst               : clock, synchronous active-high reset
//   alloc_req              : request for a free OVC
//   alloc_gnt, alloc_vc    : registered grant pulse and granted OVC
//   flit_in, valid_in,
//   vc_in                  : flit from the switch and the OVC it travels on
//   flit_out, valid_out,
//   vc_out                 : registered flit to the link
//   credit_valid, credit_vc: one returned credit and its OVC
//   credit_ok              : per-OVC credit count > 0
//   vc_busy                : per-OVC ownership
//   err                    : sticky protocol error
module ovc_credit_tx
  import ovc_credit_tx_pkg::*;
#(
  parameter int NUM_VC  = 4,
  parameter int VC_SIZE = ovc_credit_tx_pkg::VC_SIZE,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [VC_W-1:0]      alloc_vc,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 valid_in,
  input  logic [VC_W-1:0]      vc_in,
  output logic [FLIT_SIZE-1:0] flit_out,
  output logic                 valid_out,
  output logic [VC_W-1:0]      vc_out,
  input  logic                 credit_valid,
  input  logic [VC_W-1:0]      credit_vc,
  output logic [NUM_VC-1:0]    credit_ok,
  output logic [NUM_VC-1:0]    vc_busy,
  output logic                 err
);

  localparam int CNT_W = $clog2(VC_SIZE + 1);

  ovc_state_e [NUM_VC-1:0]           state_q, state_d;
  logic [VC_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                              alloc_gnt_q, alloc_gnt_d;
  logic [VC_W-1:0]                   alloc_vc_q, alloc_vc_d;
  logic [FLIT_SIZE-1:0]              flit_out_q, flit_out_d;
  logic                              valid_out_q, valid_out_d;
  logic [VC_W-1:0]                   vc_out_q, vc_out_d;
  logic                              err_q, err_d;

  logic [NUM_VC-1:0]                 dec, inc, nonzero, underflow, overflow;
  logic [NUM_VC-1:0][CNT_W-1:0]      count;

  logic                              found;
  logic [VC_W-1:0]                   grant_idx;
  int unsigned                       idx;
  logic                              send_ok;
  logic                              send_last;

  // Per-OVC credit counters.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    ovc_credit_tx_credit_counter #(
      .VC_SIZE (VC_SIZE),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .dec       (dec[i]),
      .inc       (inc[i]),
      .count     (count[i]),
      .nonzero   (nonzero[i]),
      .underflow (underflow[i]),
      .overflow  (overflow[i])
    );
    assign dec[i]       = valid_in && (vc_in == VC_W'(i));
    assign inc[i]       = credit_valid && (credit_vc == VC_W'(i));
    assign credit_ok[i] = (count[i] != '0);
    assign vc_busy[i]   = (state_q[i] == BUSY);
  end

  always_comb begin
    // Round-robin search over the pre-edge state: an OVC released this cycle
    // is still BUSY here and therefore not granted until the next cycle.
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_VC;
      if (!found && state_q[idx] == IDLE) begin
        found     = 1'b1;
        grant_idx = VC_W'(idx);
      end
    end

    send_last = is_last_flit(flit_in[FLIT_SIZE-1 -: HEADER_LEN]);
    send_ok   = valid_in & nonzero[vc_in];

    state_d = state_q;
    if (send_ok && send_last)
      state_d[vc_in] = IDLE;
    if (alloc_req && found)
      state_d[grant_idx] = BUSY;

    rr_ptr_d    = (alloc_req && found) ? VC_W'((int'(grant_idx) + 1) % NUM_VC) : rr_ptr_q;
    alloc_gnt_d = alloc_req & found;
    alloc_vc_d  = (alloc_req && found) ? grant_idx : '0;

    valid_out_d = send_ok;
    flit_out_d  = send_ok ? flit_in : flit_out_q;
    vc_out_d    = send_ok ? vc_in   : vc_out_q;

    err_d = err_q | (|underflow) | (|overflow) |
            (valid_in && state_q[vc_in] == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) state_q[i] <= IDLE;
      rr_ptr_q    <= '0;
      alloc_gnt_q <= 1'b0;
      alloc_vc_q  <= '0;
      flit_out_q  <= '0;
      valid_out_q <= 1'b0;
      vc_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alloc_gnt_q <= alloc_gnt_d;
      alloc_vc_q  <= alloc_vc_d;
      flit_out_q  <= flit_out_d;
      valid_out_q <= valid_out_d;
      vc_out_q    <= vc_out_d;
      err_q       <= err_d;
    end
  end

  assign alloc_gnt = alloc_gnt_q;
  assign alloc_vc  = alloc_vc_q;
  assign flit_out  = flit_out_q;
  assign valid_out = valid_out_q;
  assign vc_out    = vc_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ovc_credit_tx.sv
// Self-checking bench for ovc_credit_tx: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_ovc_credit_tx;
  import ovc_credit_tx_pkg::*;

  localparam int NV = 4;
  localparam int VS = 8;
  localparam int FS = FLIT_SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [1:0]    alloc_vc;
  logic [FS-1:0] flit_in;
  logic          valid_in;
  logic [1:0]    vc_in;
  logic [FS-1:0] flit_out;
  logic          valid_out;
  logic [1:0]    vc_out;
  logic          credit_valid;
  logic [1:0]    credit_vc;
  logic [NV-1:0] credit_ok;
  logic [NV-1:0] vc_busy;
  logic          err;

  always #5 clk = ~clk;

  ovc_credit_tx #(.NUM_VC(NV), .VC_SIZE(VS)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_vc     (alloc_vc),
    .flit_in      (flit_in),
    .valid_in     (valid_in),
    .vc_in        (vc_in),
    .flit_out     (flit_out),
    .valid_out    (valid_out),
    .vc_out       (vc_out),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .credit_ok    (credit_ok),
    .vc_busy      (vc_busy),
    .err          (err)
  );

  // Observed internal credit counts, packed one nibble per OVC.
  logic [NV-1:0][3:0] obs_cnt;
  assign obs_cnt[0] = dut.g_vc[0].u_cnt.count;
  assign obs_cnt[1] = dut.g_vc[1].u_cnt.count;
  assign obs_cnt[2] = dut.g_vc[2].u_cnt.count;
  assign obs_cnt[3] = dut.g_vc[3].u_cnt.count;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state.
  int            m_cnt [NV];
  bit            m_busy[NV];
  int            m_rr;
  bit            m_err;
  bit            e_gnt;
  int            e_avc;
  bit            e_vout;
  logic [FS-1:0] e_flit;
  int            e_vcout;

  function automatic logic [FS-1:0] mkf(input logic [HEADER_LEN-1:0] t);
    logic [FS-1:0] v;
    v = $urandom;
    v[FS-1 -: HEADER_LEN] = t;
    return v;
  endfunction

  task automatic step(input bit r, input bit req, input bit vin, input logic [FS-1:0] f,
                      input int vci, input bit cv, input int cvc);
    bit                    g;
    int                    gv;
    int                    id;
    bit                    ok;
    int                    nc;
    logic [FS-1:0]         ff;
    logic [HEADER_LEN-1:0] t;
    logic [NV-1:0]         e_cok;
    logic [NV-1:0]         e_busy;
    logic [NV-1:0][3:0]    e_cnt;
    rst = r; alloc_req = req; valid_in = vin; flit_in = f; vc_in = 2'(vci);
    credit_valid = cv; credit_vc = 2'(cvc);
    ff = f; t = ff[FS-1 -: HEADER_LEN];
    if (r) begin
      for (int i = 0; i < NV; i++) begin m_cnt[i] = VS; m_busy[i] = 0; end
      m_rr = 0; m_err = 0; e_gnt = 0; e_avc = 0; e_vout = 0; e_flit = '0; e_vcout = 0;
    end else begin
      g = 0; gv = 0;
      if (req)
        for (int k = 0; k < NV; k++) begin
          id = (m_rr + k) % NV;
          if (!g && !m_busy[id]) begin g = 1; gv = id; end
        end
      ok = vin && (m_cnt[vci] > 0);
      if (vin && (m_cnt[vci] == 0 || !m_busy[vci])) m_err = 1;
      for (int i = 0; i < NV; i++) begin
        nc = m_cnt[i] - ((ok && vci == i) ? 1 : 0) + ((cv && cvc == i) ? 1 : 0);
        if (nc > VS) begin m_err = 1; nc = VS; end
        m_cnt[i] = nc;
      end
      if (ok && (t == TAIL_FLIT || t == SINGLE_FLIT)) m_busy[vci] = 0;
      if (g) begin m_busy[gv] = 1; m_rr = (gv + 1) % NV; end
      e_gnt = g; e_avc = g ? gv : 0; e_vout = ok;
      if (ok) begin e_flit = f; e_vcout = vci; end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      e_cok[i] = (m_cnt[i] > 0); e_busy[i] = m_busy[i]; e_cnt[i] = 4'(m_cnt[i]);
    end
    chk("alloc_gnt", alloc_gnt, e_gnt);
    chk("alloc_vc",  alloc_vc,  e_avc);
    chk("valid_out", valid_out, e_vout);
    chk("flit_out",  flit_out,  e_flit);
    chk("vc_out",    vc_out,    e_vcout);
    chk("credit_ok", credit_ok, e_cok);
    chk("vc_busy",   vc_busy,   e_busy);
    chk("err",       err,       m_err);
    chk("counts",    obs_cnt,   e_cnt);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic rand_cycle();
    int p;
    logic [HEADER_LEN-1:0] t;
    p = $urandom_range(0, 3);
    t = (p == 0) ? HEAD_FLIT : (p == 1) ? TAIL_FLIT : (p == 2) ? SINGLE_FLIT : BODY_FLIT;
    step(0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6), mkf(t),
         $urandom_range(0, NV-1), ($urandom_range(0, 9) < 6), $urandom_range(0, NV-1));
  endtask

  initial begin
    // Reset, then idle.
    step(1, 0, 0, '0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0);
    idle();
    chk("rst_cok",  credit_ok, 4'b1111);
    chk("rst_busy", vc_busy,   4'b0000);
    chk("rst_err",  err,       1'b0);
    chk("rst_cnt",  obs_cnt,   16'h8888);

    // Allocation order 0,1,2,3 then nothing.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, '0, 0, 0, 0);
      chk("ord_gnt", alloc_gnt, 1'b1);
      chk("ord_vc",  alloc_vc,  k);
    end
    step(0, 1, 0, '0, 0, 0, 0);
    chk("ord_nogrant", alloc_gnt, 1'b0);
    chk("ord_busy",    vc_busy,   4'b1111);

    // Exhaust OVC 1, then a dropped ninth flit.
    for (int k = 0; k < 8; k++) step(0, 0, 1, mkf(BODY_FLIT), 1, 0, 0);
    chk("exh_cok1", credit_ok[1], 1'b0);
    chk("exh_err0", err, 1'b0);
    step(0, 0, 1, mkf(BODY_FLIT), 1, 0, 0);
    chk("exh_drop", valid_out, 1'b0);
    chk("exh_err",  err, 1'b1);

    // OVC 2 down to 3, then send + credit in the same cycle.
    for (int k = 0; k < 5; k++) step(0, 0, 1, mkf(BODY_FLIT), 2, 0, 0);
    step(0, 0, 1, mkf(BODY_FLIT), 2, 1, 2);
    chk("sim_cnt2", obs_cnt[2], 4'd3);
    chk("sim_cok2", credit_ok[2], 1'b1);

    // Release and re-allocation.
    step(0, 0, 1, mkf(TAIL_FLIT), 3, 0, 0);
    step(0, 1, 1, mkf(TAIL_FLIT), 0, 0, 0);
    chk("rel_gnt", alloc_gnt, 1'b1);
    chk("rel_vc",  alloc_vc,  2'd3);
    chk("rel_busy0", vc_busy[0], 1'b0);
    step(0, 1, 0, '0, 0, 0, 0);
    chk("rel_regnt", alloc_gnt, 1'b1);
    chk("rel_revc",  alloc_vc,  2'd0);

    // Credit overflow on a full OVC after a clean reset.
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 3);
    chk("ovf_cnt3", obs_cnt[3], 4'd8);
    chk("ovf_err",  err, 1'b1);

    // Random traffic, a reset in the middle of it, more traffic.
    for (int k = 0; k < 200; k++) rand_cycle();
    step(1, 1, 1, mkf(SINGLE_FLIT), 1, 1, 2);
    chk("mid_cok",  credit_ok, 4'b1111);
    chk("mid_busy", vc_busy,   4'b0000);
    chk("mid_vout", valid_out, 1'b0);
    chk("mid_gnt",  alloc_gnt, 1'b0);
    chk("mid_err",  err,       1'b0);
    chk("mid_cnt",  obs_cnt,   16'h8888);
    for (int k = 0; k < 300; k++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ovc_credit_tx.md
# ovc_credit_tx

Output-port transmit controller for one router output port. It owns the downstream virtual channels (OVCs) of that port and allocates a free OVC to a requesting head/single flit. It keeps one credit counter per OVC, driven down by transmitted flits and up by credits returned from the downstream input VC. It drives the per-OVC credit-available bits that gate consumption in the upstream input VCs.

## Interface
Parameters:
- NUM_VC, 4: OVCs on this port; index width VC_W = $clog2(NUM_VC).
- VC_SIZE, 8: downstream VC buffer depth, which is the initial and maximum credit count.
- FLIT_SIZE, HEADER_LEN: from the shared package. The flit type is flit[FLIT_SIZE-1 -: HEADER_LEN].

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- alloc_req  in  1  a head/single flit requests an OVC
- alloc_gnt  out  1  OVC granted (registered pulse)
- alloc_vc  out  VC_W  granted OVC index, valid with alloc_gnt
- flit_in  in  FLIT_SIZE  flit from switch
- valid_in  in  1  flit_in valid
- vc_in  in  VC_W  OVC that flit_in travels on
- flit_out  out  FLIT_SIZE  flit to link (registered)
- valid_out  out  1  flit_out valid
- vc_out  out  VC_W  OVC tag for flit_out
- credit_valid  in  1  downstream returns one credit
- credit_vc  in  VC_W  OVC of returned credit
- credit_ok  out  NUM_VC  bit i = credit count of OVC i > 0 (combinational from registers)
- vc_busy  out  NUM_VC  bit i = OVC i owned by a packet
- err  out  1  sticky protocol error

## Operation
- Per-OVC state:
  - IDLE: free.
  - BUSY: owned from grant until its tail/single flit is sent.
- Per-OVC credit counter, range 0..VC_SIZE, width $clog2(VC_SIZE+1).
- Allocation:
  - alloc_req with at least one IDLE OVC: choose the first IDLE OVC searching round-robin from rr_ptr.
  - Mark it BUSY and set rr_ptr = chosen+1 (mod NUM_VC).
  - No IDLE OVC: no grant. The requester holds alloc_req.
  - Allocation does not require credits.
- Send, on valid_in:
  - Register flit_in/vc_in to the outputs and decrement the vc_in counter.
  - If the flit type is TAIL_FLIT or SINGLE_FLIT, return vc_in to IDLE.
- Credit return: credit_valid increments the credit_vc counter.
- Same-OVC send and credit return in one cycle: the counter is unchanged.
- Errors (each sets err; err clears only on rst):
  - Send with count 0: flit is dropped (valid_out=0) and the counter stays 0.
  - Send on an IDLE OVC: flit is still forwarded.
  - Credit return with count = VC_SIZE and no same-cycle send: counter saturates.
- Release and allocation in the same cycle: the released OVC is not allocatable until the next cycle, because allocation sees the pre-edge state.

## Timing
- Reset values:
  - All counters = VC_SIZE, all OVCs IDLE, rr_ptr = 0.
  - alloc_gnt = 0, alloc_vc = 0, valid_out = 0, flit_out = 0, vc_out = 0, err = 0.
  - credit_ok = all ones, vc_busy = 0.
- Allocation latency is 1:
  - alloc_req sampled at edge N; alloc_gnt/alloc_vc valid in cycle N+1.
  - vc_busy updates at the same edge.
  - A request held through N+1 is a new request.
- Send latency is 1: valid_in at edge N gives valid_out/flit_out/vc_out in cycle N+1.
- Counter updates at the edge where valid_in/credit_valid are sampled, so credit_ok reflects them in the next cycle. A 1-credit OVC sent at edge N shows credit_ok=0 from N+1.
- rst mid-operation: everything returns to reset values at the next edge. In-flight flits and credits are discarded.

## Structure
- Shared package (para): FLIT_SIZE, HEADER_LEN, HEAD_FLIT/BODY_FLIT/TAIL_FLIT/SINGLE_FLIT, VC_SIZE, and an OVC state typedef (IDLE, BUSY).
- Sub-module credit_counter: one per OVC (generate loop).
  - Inputs: dec, inc.
  - Outputs: count, nonzero, underflow/overflow error pulses.
- Top level holds the round-robin allocator, output registers and err.

## Test plan
- Reset, then idle: credit_ok = 4'b1111, vc_busy = 0, err = 0, every counter = 8.
- Allocation order: alloc_req held for 5 cycles with NUM_VC=4 gives grants with alloc_vc 0,1,2,3 in successive cycles, then no grant; vc_busy = 4'b1111.
- Credit exhaustion on OVC 1: 8 body flits on OVC 1 with no credits back gives credit_ok[1]=0. A 9th flit is dropped, valid_out stays 0 and err=1.
- Simultaneous send and credit return on OVC 2 with count 3: count stays 3 and credit_ok[2] stays 1.
- Release and re-allocation: TAIL flit on busy OVC 0 with alloc_req in the same cycle grants another IDLE OVC, not 0. vc_busy[0]=0 the next cycle, and a following request can get OVC 0 when the rr_ptr search reaches it.
- Credit overflow: credit return on OVC 3 at count 8 leaves the count at 8 and sets err=1. Then rst in the middle of traffic restores all reset values at the next edge.
